vga_console_ctl: RTL and testbench
==================================

VGA_CONSOLE_CTL -- requirements
Module: vga_console_ctl

Interface
REQ-001 The block SHALL have parameter COLS, default 40, meaning text columns per row.
REQ-002 The block SHALL have parameter ROWS, default 30, meaning text rows.
REQ-003 The block SHALL have parameter BLANK, default 8'h20, meaning the fill character for clears.
REQ-004 The block SHALL have port clk25m, input, width 1: the single pixel/system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, width 1: the character is valid.
REQ-007 The block SHALL have port in_data, input, width 8: the character code.
REQ-008 The block SHALL have port in_ready, output, width 1: the block accepts a character this cycle.
REQ-009 The block SHALL have port clr, input, width 1: clear-screen request, level-sampled.
REQ-010 The block SHALL have port busy, output, width 1: a clear sequence is in progress.
REQ-011 The block SHALL have port cursor_col, output, width 6, and port cursor_row, output, width 5: the current cursor position.
REQ-012 The block SHALL have port vram_waddr, output, width 11; port vram_wdata, output, width 8; and port vram_we, output, width 1: the VRAM write port, on clk25m.

Function
REQ-013 The block SHALL have states IDLE, CLEAR_ROW and CLEAR_ALL.
REQ-014 busy SHALL equal (state != IDLE).
REQ-015 in_ready SHALL equal (state == IDLE && !clr).
REQ-016 A character SHALL be accepted on a cycle with in_valid && in_ready.
- Back-to-back acceptance (one character per cycle) is allowed.
REQ-017 All vram_* outputs SHALL be registered.
- A write caused by an acceptance or a clear step appears the cycle after it.
- vram_we is 0 in every cycle with no write.
REQ-018 The cell address SHALL equal row*COLS+col, computed exactly within 11 bits; no wrap for COLS*ROWS <= 2048.
REQ-019 An accepted printable character (0x20..0x7E) SHALL be written (vram_we=1, vram_waddr=cursor address, vram_wdata=in_data).
- Then cursor_col increments.
- If cursor_col was COLS-1: cursor_col becomes 0 and a row advance occurs.
REQ-020 An accepted 0x0A SHALL cause cursor_col=0 and a row advance, with no character write.
REQ-021 An accepted 0x0D SHALL cause cursor_col=0 with no write.
REQ-022 An accepted 0x08 SHALL decrement cursor_col if it is >0, otherwise leave it unchanged, with no write.
REQ-023 All other accepted codes SHALL be consumed with no write and no cursor change.
REQ-024 A row advance SHALL set cursor_row to cursor_row+1, wrapping ROWS-1 to 0.
- It then enters CLEAR_ROW for the destination row.
REQ-025 CLEAR_ROW SHALL issue COLS consecutive writes, one per cycle, data BLANK.
- Addresses ascend from row*COLS to row*COLS+COLS-1.
- It then returns to IDLE.
REQ-026 In IDLE, clr=1 SHALL take priority over in_valid (no acceptance that cycle).
- It sets the cursor to (0,0) and enters CLEAR_ALL.
REQ-027 CLEAR_ALL SHALL issue COLS*ROWS consecutive writes, one per cycle, data BLANK.
- Addresses run 0..COLS*ROWS-1.
- It then returns to IDLE.
REQ-028 clr asserted during CLEAR_ROW SHALL be latched into a pending flag.
- CLEAR_ALL starts the cycle after CLEAR_ROW completes, with the cursor set to (0,0).
REQ-029 clr asserted during CLEAR_ALL SHALL be ignored.
REQ-030 The cursor SHALL change only on an acceptance or on CLEAR_ALL entry.

Reset
REQ-031 While rst_n=0, the block SHALL hold these values at the clock edge:
- state=CLEAR_ALL, clear pointer=0, cursor (0,0), pending flag=0.
- vram_we=0, vram_waddr=0, vram_wdata=0.
- in_ready=0, busy=1.
REQ-032 After rst_n rises, the first CLEAR_ALL write (addr 0) SHALL appear one cycle later.
REQ-033 rst_n low mid-sequence SHALL abandon the sequence and restart CLEAR_ALL from addr 0 on release.

Verification
REQ-034 Release reset -> 1200 consecutive writes, addr 0..1199, data 0x20, with in_ready=0 throughout; then in_ready=1 and cursor (0,0).
REQ-035 Send 'A','B' on consecutive cycles -> consecutive writes addr 0/0x41 then addr 1/0x42; cursor_col=2; in_ready stays 1.
REQ-036 Send 40 printable chars in row 0 -> last write addr 39.
- Then cursor (col 0,row 1).
- Then 40 writes addr 40..79 data 0x20 with in_ready=0, then IDLE.
REQ-037 Cursor at row 29, col 7, send 0x0A -> cursor (0,0), 40 blank writes addr 0..39, no write at 0x0A.
REQ-038 Cursor at col 0, send 0x08 -> no write, cursor unchanged.
- Then at col 5, send 0x0D -> col 0, no write.
- Then send 0x07 -> no effect.
REQ-039 In IDLE, assert clr with in_valid=1 the same cycle -> character not accepted, cursor (0,0), 1200-write clear.
- A clr during a CLEAR_ROW starts CLEAR_ALL immediately after the row's 40th write.

Source files
------------

// File: rtl/vga_console_ctl.sv
// Text console write controller: turns a character stream into VRAM cell writes with cursor and clears.
// Latency: each VRAM write is registered and appears one cycle after its acceptance or clear step.
// Backpressure: in_ready drops while a row/screen clear runs or while clr is asserted.
//
// Ports:
//   clk25m, rst_n          - pixel/system clock, synchronous active-low reset
//   in_valid/in_data/in_ready - character input handshake
//   clr, busy              - clear-screen request (level), clear-in-progress status
//   cursor_col, cursor_row - current cursor position
//   vram_waddr/wdata/we    - registered VRAM write port
module vga_console_ctl #(
    parameter int          COLS  = 40,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk25m,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        clr,
    output logic        busy,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic [10:0] vram_waddr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we
);

    localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [10:0] COLS_W    = 11'(COLS);
    localparam logic [10:0] ROW_LAST  = 11'(COLS - 1);
    localparam logic [10:0] CELL_LAST = 11'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR_ROW = 2'd1,
        CLEAR_ALL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] ptr;          // clear step index within the current sequence
    logic        pending;      // clr seen while a row clear was running

    logic        accept;
    logic        is_print;
    logic        is_lf;
    logic        is_cr;
    logic        is_bs;
    logic        col_at_end;
    logic        row_adv;
    logic        enter_all;
    logic [10:0] row_base;
    logic [10:0] cell_addr;
    logic [4:0]  row_inc;

    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    // Character decode and address arithmetic
    always_comb begin
        accept     = in_valid && in_ready;
        is_print   = (in_data >= 8'h20) && (in_data <= 8'h7E);
        is_lf      = (in_data == 8'h0A);
        is_cr      = (in_data == 8'h0D);
        is_bs      = (in_data == 8'h08);
        col_at_end = (cursor_col == LAST_COL);
        row_adv    = accept && ((is_print && col_at_end) || is_lf);
        row_base   = 11'(cursor_row) * COLS_W;
        cell_addr  = row_base + 11'(cursor_col);
        row_inc    = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
    end

    // State register
    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            state <= CLEAR_ALL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR_ALL;
                end else if (row_adv) begin
                    state_nxt = CLEAR_ROW;
                end
            end
            CLEAR_ROW: begin
                // A clr arriving on the final row step still counts as pending.
                if (ptr == ROW_LAST) begin
                    state_nxt = (pending || clr) ? CLEAR_ALL : IDLE;
                end
            end
            CLEAR_ALL: begin
                if (ptr == CELL_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = CLEAR_ALL;
        endcase
    end

    // Output logic: status flags and the write command that gets registered
    always_comb begin
        in_ready = (state == IDLE) && !clr;
        busy     = (state != IDLE);
        wr_en    = 1'b0;
        wr_addr  = 11'd0;
        wr_data  = 8'd0;
        case (state)
            IDLE: begin
                if (accept && is_print) begin
                    wr_en   = 1'b1;
                    wr_addr = cell_addr;
                    wr_data = in_data;
                end
            end
            CLEAR_ROW: begin
                wr_en   = 1'b1;
                wr_addr = row_base + ptr;
                wr_data = BLANK;
            end
            CLEAR_ALL: begin
                wr_en   = 1'b1;
                wr_addr = ptr;
                wr_data = BLANK;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    assign enter_all = (state != CLEAR_ALL) && (state_nxt == CLEAR_ALL);

    // Datapath: write port, clear pointer, pending flag, cursor
    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            vram_we    <= 1'b0;
            vram_waddr <= 11'd0;
            vram_wdata <= 8'd0;
            ptr        <= 11'd0;
            pending    <= 1'b0;
            cursor_col <= 6'd0;
            cursor_row <= 5'd0;
        end else begin
            vram_we    <= wr_en;
            vram_waddr <= wr_addr;
            vram_wdata <= wr_data;

            if (state_nxt != state) begin
                ptr <= 11'd0;
            end else if (state != IDLE) begin
                ptr <= ptr + 11'd1;
            end

            if (state == CLEAR_ROW && state_nxt == CLEAR_ROW) begin
                pending <= pending || clr;
            end else begin
                pending <= 1'b0;
            end

            if (enter_all) begin
                cursor_col <= 6'd0;
                cursor_row <= 5'd0;
            end else if (accept) begin
                if (is_print) begin
                    if (col_at_end) begin
                        cursor_col <= 6'd0;
                        cursor_row <= row_inc;
                    end else begin
                        cursor_col <= cursor_col + 6'd1;
                    end
                end else if (is_lf) begin
                    cursor_col <= 6'd0;
                    cursor_row <= row_inc;
                end else if (is_cr) begin
                    cursor_col <= 6'd0;
                end else if (is_bs && cursor_col != 6'd0) begin
                    cursor_col <= cursor_col - 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_console_ctl.sv
// Directed bench for vga_console_ctl: reset, printing, control codes, row and screen clears.
// Inputs change on the falling edge; writes are logged 5 ns after each rising edge.
// Status outputs are sampled on the falling edge.
module tb_vga_console_ctl;

    logic        clk25m = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        clr;
    logic        busy;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [10:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic        vram_we;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t wq[$];

    vga_console_ctl #(.COLS(40), .ROWS(30), .BLANK(8'h20)) dut (
        .clk25m    (clk25m),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .clr       (clr),
        .busy      (busy),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .vram_waddr(vram_waddr),
        .vram_wdata(vram_wdata),
        .vram_we   (vram_we)
    );

    always #20 clk25m = ~clk25m;

    always @(posedge clk25m) begin
        cyc = cyc + 1;
        #5;
        if (vram_we === 1'b1) begin
            wq.push_back('{addr: int'(vram_waddr), data: int'(vram_wdata), cyc: cyc});
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        in_data  = c;
        @(negedge clk25m);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk25m);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk({tag, "_timeout"}, 0, 1);
    endtask

    // Checks n logged writes from index idx: ascending addresses from base, blank data, one per cycle.
    task automatic chk_run(input string tag, input int idx, input int base, input int n);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (idx + i >= wq.size()) begin
                errs++;
            end else begin
                if (wq[idx+i].addr != base + i) errs++;
                if (wq[idx+i].data != 32'h20) errs++;
                if (i > 0 && wq[idx+i].cyc != wq[idx+i-1].cyc + 1) errs++;
            end
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clr      = 1'b0;
        repeat (3) @(negedge clk25m);

        // Reset values
        chk("rst_we", int'(vram_we), 0);
        chk("rst_waddr", int'(vram_waddr), 0);
        chk("rst_wdata", int'(vram_wdata), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cursor", int'({cursor_row, cursor_col}), 0);

        // Power-up clear: first write one cycle after release
        wq.delete();
        rst_n = 1'b1;
        @(negedge clk25m);
        chk("first_we", int'(vram_we), 1);
        chk("first_addr", int'(vram_waddr), 0);
        chk("clr_in_ready_low", int'(in_ready), 0);
        wait_idle("boot", 1300);
        chk("boot_count", wq.size(), 1200);
        chk_run("boot_run", 0, 0, 1200);
        chk("boot_busy", int'(busy), 0);
        chk("boot_col", int'(cursor_col), 0);
        chk("boot_row", int'(cursor_row), 0);

        // 'A','B' back to back
        wq.delete();
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clk25m);
        chk("ab_ready_mid", int'(in_ready), 1);
        in_data = 8'h42;
        @(negedge clk25m);
        in_valid = 1'b0;
        chk("ab_count", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("a_addr", wq[0].addr, 0);
            chk("a_data", wq[0].data, 8'h41);
            chk("b_addr", wq[1].addr, 1);
            chk("b_data", wq[1].data, 8'h42);
            chk("ab_consec", wq[1].cyc - wq[0].cyc, 1);
        end
        chk("ab_col", int'(cursor_col), 2);
        chk("ab_ready", int'(in_ready), 1);

        // CR back to column 0, then fill row 0
        wq.delete();
        send(8'h0D);
        chk("cr_col", int'(cursor_col), 0);
        chk("cr_nowrite", wq.size(), 0);
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = 8'(8'h21 + i);
            @(negedge clk25m);
        end
        in_valid = 1'b0;
        chk("row0_count", wq.size(), 40);
        if (wq.size() == 40) begin
            chk("row0_last_addr", wq[39].addr, 39);
            chk("row0_last_data", wq[39].data, 8'h48);
        end
        chk("wrap_col", int'(cursor_col), 0);
        chk("wrap_row", int'(cursor_row), 1);
        chk("wrap_ready", int'(in_ready), 0);
        wq.delete();
        wait_idle("row1", 100);
        chk("row1_count", wq.size(), 40);
        chk_run("row1_run", 0, 40, 40);

        // Walk down to row 29, col 7, then LF wraps to row 0
        for (int r = 0; r < 28; r++) begin
            send(8'h0A);
            wait_idle("lf_walk", 100);
        end
        for (int i = 0; i < 7; i++) send(8'h61);
        chk("r29_row", int'(cursor_row), 29);
        chk("r29_col", int'(cursor_col), 7);
        wq.delete();
        send(8'h0A);
        chk("lfwrap_col", int'(cursor_col), 0);
        chk("lfwrap_row", int'(cursor_row), 0);
        chk("lfwrap_nowrite", wq.size(), 0);
        wait_idle("lfwrap", 100);
        chk("lfwrap_count", wq.size(), 40);
        chk_run("lfwrap_run", 0, 0, 40);

        // Control codes
        wq.delete();
        send(8'h08);
        chk("bs0_col", int'(cursor_col), 0);
        chk("bs0_row", int'(cursor_row), 0);
        for (int i = 0; i < 5; i++) send(8'h62);
        chk("five_col", int'(cursor_col), 5);
        wq.delete();
        send(8'h07);
        chk("bel_col", int'(cursor_col), 5);
        chk("bel_row", int'(cursor_row), 0);
        send(8'h08);
        chk("bs_col", int'(cursor_col), 4);
        send(8'h0D);
        chk("cr2_col", int'(cursor_col), 0);
        chk("ctrl_nowrite", wq.size(), 0);

        // clr beats in_valid in the same cycle
        send(8'h78);
        send(8'h79);
        wq.delete();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #1;
        chk("clr_blocks_ready", int'(in_ready), 0);
        @(negedge clk25m);
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_cursor", int'({cursor_row, cursor_col}), 0);
        chk("clr_busy", int'(busy), 1);
        wait_idle("clrall", 1300);
        chk("clrall_count", wq.size(), 1200);
        chk_run("clrall_run", 0, 0, 1200);

        // clr during a row clear chains into a full clear
        wq.delete();
        send(8'h0A);
        chk("chain_row", int'(cursor_row), 1);
        clr = 1'b1;
        @(negedge clk25m);
        clr = 1'b0;
        wait_idle("chain", 1400);
        chk("chain_count", wq.size(), 1240);
        chk_run("chain_run_row", 0, 40, 40);
        chk_run("chain_run_all", 40, 0, 1200);
        if (wq.size() > 40) chk("chain_gap", wq[40].cyc - wq[39].cyc, 1);
        chk("chain_cursor", int'({cursor_row, cursor_col}), 0);

        // Reset in the middle of a clear restarts from address 0
        send(8'h63);
        clr = 1'b1;
        @(negedge clk25m);
        clr = 1'b0;
        repeat (100) @(negedge clk25m);
        rst_n = 1'b0;
        repeat (2) @(negedge clk25m);
        chk("mid_rst_we", int'(vram_we), 0);
        chk("mid_rst_busy", int'(busy), 1);
        wq.delete();
        rst_n = 1'b1;
        wait_idle("rerun", 1300);
        chk("rerun_count", wq.size(), 1200);
        chk_run("rerun_run", 0, 0, 1200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
